// File: rtl/rv32i_pkg.sv
`default_nettype none
// rv32i_pkg -- shared RV32I front-end types and halfword sizing constants. Rev 1.0
package rv32i_pkg;

  typedef logic [31:0] rv32i_t;

  localparam int HW_CNT_W = 3;
  typedef logic [HW_CNT_W-1:0] hw_cnt_t;

  localparam hw_cnt_t INSTR_SIZE_16 = hw_cnt_t'(1);
  localparam hw_cnt_t INSTR_SIZE_32 = hw_cnt_t'(2);

  function automatic logic is_instr32(input logic [15:0] hw);
    return hw[1:0] == 2'b11;
  endfunction

  function automatic hw_cnt_t instr_size(input logic [15:0] hw);
    return is_instr32(hw) ? INSTR_SIZE_32 : INSTR_SIZE_16;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aligner_hw_fifo.sv
`default_nettype none
// aligner_hw_fifo -- 4-entry halfword shift FIFO; head is always entry 0. Rev 1.0
module aligner_hw_fifo
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        pop_i,
  input  hw_cnt_t     push_cnt_i,
  input  logic [15:0] push_hw0_i,
  input  logic [15:0] push_hw1_i,
  output hw_cnt_t     count_o,
  output hw_cnt_t     pop_cnt_o,
  output logic        instr_valid_o,
  output rv32i_t      instr_o
);

  localparam int DEPTH = 4;

  logic [15:0] hw_q [DEPTH];
  logic [15:0] hw_d [DEPTH];
  hw_cnt_t     count_q, count_d, remain;
  logic [1:0]  src;
  logic        valid_q, valid_d;
  rv32i_t      instr_q, instr_d;

  assign pop_cnt_o     = pop_i ? instr_size(hw_q[0]) : '0;
  assign count_o       = count_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;

  // Survivors shift down by the pop amount, new halfwords land right behind them.
  always_comb begin
    remain = count_q - pop_cnt_o;
    src    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hw_d[i] = hw_q[i];
      src     = 2'(i) + pop_cnt_o[1:0];
      if (hw_cnt_t'(i) < remain) begin
        hw_d[i] = hw_q[src];
      end else if (hw_cnt_t'(i) == remain && push_cnt_i != '0) begin
        hw_d[i] = push_hw0_i;
      end else if (hw_cnt_t'(i) == remain + INSTR_SIZE_16 && push_cnt_i == INSTR_SIZE_32) begin
        hw_d[i] = push_hw1_i;
      end
    end
    count_d = remain + push_cnt_i;
    if (flush_i) begin
      count_d = '0;
    end
    valid_d = (count_d >= INSTR_SIZE_32) ||
              (count_d == INSTR_SIZE_16 && !is_instr32(hw_d[0]));
    instr_d = instr_q;
    if (valid_d) begin
      instr_d = is_instr32(hw_d[0]) ? {hw_d[1], hw_d[0]} : {16'h0000, hw_d[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        hw_q[i] <= '0;
      end
      count_q <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        hw_q[i] <= hw_d[i];
      end
      count_q <= count_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_aligner.sv
`default_nettype none
// instruction_aligner -- fetches words and realigns RV32I/RVC halfwords into instructions. Rev 1.0
module instruction_aligner
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] pc_q, pc_d;
  logic        outstanding_q, outstanding_d;
  logic        epoch_q, epoch_d;
  logic        req_epoch_q, req_epoch_d;
  logic        half_skip_q, half_skip_d;

  hw_cnt_t     count, pop_cnt, push_cnt;
  logic [15:0] push_hw0, push_hw1;
  logic        pop, req_fire, rsp_take;

  assign pop       = instr_valid && instr_ready && !redirect_valid;
  assign req_valid = !rst && !outstanding_q && !redirect_valid &&
                     ((count - pop_cnt) <= INSTR_SIZE_32);
  assign req_addr  = fetch_addr_q;
  assign instr_pc  = pc_q;
  assign req_fire  = req_valid && req_ready;
  // Only the current epoch's response is kept; redirect in the same cycle wins.
  assign rsp_take  = rsp_valid && outstanding_q && (req_epoch_q == epoch_q) && !redirect_valid;

  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    epoch_d       = epoch_q;
    req_epoch_d   = req_epoch_q;
    half_skip_d   = half_skip_q;
    push_cnt      = '0;
    push_hw0      = rsp_data[15:0];
    push_hw1      = rsp_data[31:16];

    if (req_fire) begin
      outstanding_d = 1'b1;
      req_epoch_d   = epoch_q;
      fetch_addr_d  = fetch_addr_q + 32'd4;
    end
    if (rsp_valid && outstanding_q) begin
      outstanding_d = 1'b0;
    end
    if (rsp_take) begin
      if (half_skip_q) begin
        push_cnt    = INSTR_SIZE_16;
        push_hw0    = rsp_data[31:16];
        half_skip_d = 1'b0;
      end else begin
        push_cnt    = INSTR_SIZE_32;
      end
    end
    if (pop) begin
      pc_d = pc_q + {28'b0, pop_cnt, 1'b0};
    end
    if (redirect_valid) begin
      epoch_d      = ~epoch_q;
      fetch_addr_d = redirect_pc & ~32'd3;
      pc_d         = redirect_pc & ~32'd1;
      half_skip_d  = redirect_pc[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr_q  <= RESET_PC & ~32'd3;
      pc_q          <= RESET_PC & ~32'd3;
      outstanding_q <= 1'b0;
      epoch_q       <= 1'b0;
      req_epoch_q   <= 1'b0;
      half_skip_q   <= 1'b0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      epoch_q       <= epoch_d;
      req_epoch_q   <= req_epoch_d;
      half_skip_q   <= half_skip_d;
    end
  end

  aligner_hw_fifo u_fifo (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (redirect_valid),
    .pop_i         (pop),
    .push_cnt_i    (push_cnt),
    .push_hw0_i    (push_hw0),
    .push_hw1_i    (push_hw1),
    .count_o       (count),
    .pop_cnt_o     (pop_cnt),
    .instr_valid_o (instr_valid),
    .instr_o       (instr)
  );

endmodule
`default_nettype wire

// File: tb/tb_instruction_aligner.sv
`default_nettype none
// tb_instruction_aligner -- randomized bench; expected instructions come from walking a memory image by PC.
module tb_instruction_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  int          ready_mode = 0;
  int          lat_lo = 1, lat_hi = 1;
  int          n_rsp = 0, proto_err = 0;
  logic [31:0] exp_pc;

  instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // Memory model: one slot, responds lat cycles after acceptance, never reset.
  initial begin
    bit          acc, pend;
    int          cnt;
    logic [31:0] acc_addr, pend_addr;
    pend = 1'b0; cnt = 0; acc_addr = '0; pend_addr = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    forever begin
      @(negedge clk);
      acc = req_valid && req_ready;
      acc_addr = req_addr;
      if (acc && pend) proto_err++;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      rsp_data  = $urandom();
      if (acc && !pend) begin
        pend = 1'b1; pend_addr = acc_addr; cnt = $urandom_range(lat_hi, lat_lo);
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          rsp_valid = 1'b1; rsp_data = mem[pend_addr[9:2]]; pend = 1'b0; n_rsp++;
        end
      end
      case (ready_mode)
        0: req_ready = 1'b1;
        1: req_ready = 1'($urandom_range(1, 0));
        default: req_ready = 1'b0;
      endcase
    end
  end

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    logic [15:0] lo;
    lo = hw_at(pc);
    return (lo[1:0] == 2'b11) ? {hw_at(pc + 32'd2), lo} : {16'h0000, lo};
  endfunction

  function automatic logic [31:0] ref_len(input logic [31:0] pc);
    logic [15:0] lo;
    lo = hw_at(pc);
    return (lo[1:0] == 2'b11) ? 32'd4 : 32'd2;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input bit rdy, output bit fire, output logic [31:0] ins, output logic [31:0] pc);
    instr_ready = rdy;
    @(negedge clk);
    fire = instr_valid && instr_ready;
    ins  = instr;
    pc   = instr_pc;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    exp_pc = 32'h0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%0b want=0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b want=0", req_valid); end
    total++; if (req_addr !== 32'h0) begin bad++; $display("FAIL reset_req_addr got=%h want=0", req_addr); end
  endtask

  task automatic test_latency();
    int rsp_c, v_c;
    logic [31:0] gi, gp;
    mem[0] = 32'h0041_0113; mem[1] = 32'h0000_0001;
    ready_mode = 0; lat_lo = 1; lat_hi = 3;
    do_reset();
    rsp_c = -1; v_c = -1; gi = '0; gp = '0;
    for (int c = 0; c < 30; c++) begin
      instr_ready = 1'b1;
      @(negedge clk);
      if (rsp_valid && rsp_c < 0) rsp_c = c;
      if (instr_valid && v_c < 0) begin v_c = c; gi = instr; gp = instr_pc; end
      tick();
    end
    total++; if (v_c < 0 || v_c != rsp_c + 1) begin bad++; $display("FAIL latency got=%0d want=%0d", v_c, rsp_c + 1); end
    total++; if (gi !== 32'h0041_0113) begin bad++; $display("FAIL latency_instr got=%h want=00410113", gi); end
    total++; if (gp !== 32'h0) begin bad++; $display("FAIL latency_pc got=%h want=0", gp); end
  endtask

  task automatic test_directed();
    logic [31:0] ei [3];
    logic [31:0] ep [3];
    int n, k;
    bit f;
    logic [31:0] gi, gp;
    for (int tc = 0; tc < 2; tc++) begin
      if (tc == 0) begin
        mem[0] = 32'h4501_4505; n = 2;
        ei[0] = 32'h0000_4505; ep[0] = 32'h0;
        ei[1] = 32'h0000_4501; ep[1] = 32'h2;
      end else begin
        mem[0] = 32'h0113_4505; mem[1] = 32'h4505_0041; n = 3;
        ei[0] = 32'h0000_4505; ep[0] = 32'h0;
        ei[1] = 32'h0041_0113; ep[1] = 32'h2;
        ei[2] = 32'h0000_4505; ep[2] = 32'h6;
      end
      ei[2] = (tc == 0) ? 32'h0 : ei[2];
      ready_mode = 1; lat_lo = 1; lat_hi = 3;
      do_reset();
      k = 0;
      for (int c = 0; c < 80 && k < n; c++) begin
        step(1'($urandom_range(1, 0)), f, gi, gp);
        if (f) begin
          total++;
          if (gi !== ei[k] || gp !== ep[k]) begin
            bad++; $display("FAIL directed%0d_%0d got=%h@%h want=%h@%h", tc, k, gi, gp, ei[k], ep[k]);
          end
          k++;
        end
      end
      total++; if (k != n) begin bad++; $display("FAIL directed%0d_count got=%0d want=%0d", tc, k, n); end
    end
  endtask

  task automatic test_backpressure();
    int rc, acc0, k;
    bit seen, f;
    logic [31:0] hi, hp, gi, gp;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[0] = 32'h0041_0113;
    ready_mode = 0; lat_lo = 1; lat_hi = 1;
    do_reset();
    rc = 0; acc0 = n_rsp; seen = 1'b0; hi = '0; hp = '0;
    for (int c = 0; c < 12; c++) begin
      instr_ready = 1'b0;
      @(negedge clk);
      if (rc >= 2) begin
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid cyc=%0d got=%0b want=0", c, req_valid); end
      end
      if (seen) begin
        total++;
        if (instr !== hi || instr_pc !== hp) begin bad++; $display("FAIL bp_stable got=%h@%h want=%h@%h", instr, instr_pc, hi, hp); end
      end else if (instr_valid) begin
        seen = 1'b1; hi = instr; hp = instr_pc;
      end
      if (rsp_valid) rc++;
      tick();
    end
    total++; if (n_rsp - acc0 != 2) begin bad++; $display("FAIL bp_words got=%0d want=2", n_rsp - acc0); end
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      step(1'b1, f, gi, gp);
      if (f) begin
        total++;
        if (gi !== ref_instr(exp_pc) || gp !== exp_pc) begin
          bad++; $display("FAIL bp_drain got=%h@%h want=%h@%h", gi, gp, ref_instr(exp_pc), exp_pc);
        end
        exp_pc = exp_pc + ref_len(exp_pc); k++;
      end
    end
    total++; if (k != 8) begin bad++; $display("FAIL bp_drain_count got=%0d want=8", k); end
  endtask

  task automatic test_redirect_outstanding();
    bit acc, rq_seen, got;
    logic [31:0] first_addr, gi, gp;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[0]  = 32'h0041_0113;
    mem[64] = 32'h8082_0013;
    ready_mode = 0; lat_lo = 4; lat_hi = 4;
    do_reset();
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      instr_ready = 1'b1;
      @(negedge clk);
      acc = req_valid && req_ready;
      tick();
    end
    total++; if (!acc) begin bad++; $display("FAIL redir_accept got=0 want=1"); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || instr_pc !== 32'h102) begin
      bad++; $display("FAIL redir_state got=%0b@%h want=0@00000102", instr_valid, instr_pc);
    end
    rq_seen = 1'b0; got = 1'b0; first_addr = '0; gi = '0; gp = '0;
    for (int c = 0; c < 30 && !got; c++) begin
      instr_ready = 1'b1;
      @(negedge clk);
      if (req_valid && !rq_seen) begin rq_seen = 1'b1; first_addr = req_addr; end
      if (instr_valid) begin got = 1'b1; gi = instr; gp = instr_pc; end
      tick();
    end
    total++; if (first_addr !== 32'h100) begin bad++; $display("FAIL redir_req_addr got=%h want=00000100", first_addr); end
    total++; if (!got || gi !== 32'h0000_8082 || gp !== 32'h102) begin
      bad++; $display("FAIL redir_first got=%h@%h want=00008082@00000102", gi, gp);
    end
    total++; if (proto_err != 0) begin bad++; $display("FAIL redir_one_outstanding got=%0d want=0", proto_err); end
  endtask

  task automatic test_random();
    bit rd, f, prev_wait;
    logic [31:0] prev_addr, a, rpc;
    int cons;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    ready_mode = 1; lat_lo = 1; lat_hi = 4;
    do_reset();
    prev_wait = 1'b0; prev_addr = '0; cons = 0;
    for (int c = 0; c < 3000; c++) begin
      rd = ($urandom_range(39, 0) == 0);
      rpc = $urandom() & 32'hFFFF_FFFE;
      if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF8 + 32'($urandom_range(3, 0) * 2);
      redirect_valid = rd; redirect_pc = rpc;
      instr_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      f = instr_valid && instr_ready && !rd;
      if (f) begin
        total++; cons++;
        if (instr !== ref_instr(exp_pc) || instr_pc !== exp_pc) begin
          bad++; $display("FAIL rnd_instr got=%h@%h want=%h@%h", instr, instr_pc, ref_instr(exp_pc), exp_pc);
        end
        exp_pc = exp_pc + ref_len(exp_pc);
      end
      if (rd) begin
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rnd_req_in_redirect got=%0b want=0", req_valid); end
      end else if (prev_wait) begin
        total++; if (req_valid !== 1'b1 || req_addr !== prev_addr) begin
          bad++; $display("FAIL rnd_req_hold got=%0b@%h want=1@%h", req_valid, req_addr, prev_addr);
        end
      end
      if (req_valid) begin
        a = req_addr;
        total++; if (a[1:0] !== 2'b00) begin bad++; $display("FAIL rnd_req_align got=%h", a); end
      end
      prev_wait = req_valid && !req_ready;
      prev_addr = req_addr;
      tick();
      if (rd) begin
        redirect_valid = 1'b0;
        exp_pc = rpc;
        prev_wait = 1'b0;
        total++; if (instr_valid !== 1'b0 || instr_pc !== rpc || req_addr !== (rpc & ~32'd3)) begin
          bad++; $display("FAIL rnd_redirect got=%0b@%h req=%h want=0@%h req=%h", instr_valid, instr_pc, req_addr, rpc, rpc & ~32'd3);
        end
      end
    end
    total++; if (cons < 300) begin bad++; $display("FAIL rnd_progress got=%0d want>=300", cons); end
    total++; if (proto_err != 0) begin bad++; $display("FAIL rnd_one_outstanding got=%0d want=0", proto_err); end
  endtask

  task automatic test_reset_midrequest();
    bit vseen, acc2, late, leak, f;
    logic [31:0] gi, gp;
    int rsp0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[0] = 32'h0041_0113;
    ready_mode = 0; lat_lo = 4; lat_hi = 4;
    do_reset();
    vseen = 1'b0; acc2 = 1'b0;
    for (int c = 0; c < 30 && !acc2; c++) begin
      instr_ready = 1'b0;
      @(negedge clk);
      if (instr_valid) vseen = 1'b1;
      if (vseen && req_valid && req_ready) begin acc2 = 1'b1; ready_mode = 2; end
      tick();
    end
    total++; if (!acc2) begin bad++; $display("FAIL rstmid_setup got=0 want=1"); end
    rsp0 = n_rsp;
    rst = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL rstmid_instr got=%0b %h@%h want=0 0@0", instr_valid, instr, instr_pc);
    end
    total++; if (req_valid !== 1'b0 || req_addr !== 32'h0) begin
      bad++; $display("FAIL rstmid_req got=%0b@%h want=0@0", req_valid, req_addr);
    end
    tick(); tick();
    rst = 1'b0; exp_pc = 32'h0;
    late = 1'b0; leak = 1'b0;
    for (int c = 0; c < 8; c++) begin
      instr_ready = 1'b1;
      @(negedge clk);
      if (rsp_valid) late = 1'b1;
      if (instr_valid) leak = 1'b1;
      tick();
    end
    total++; if (!late || n_rsp == rsp0) begin bad++; $display("FAIL rstmid_late_rsp got=0 want=1"); end
    total++; if (leak) begin bad++; $display("FAIL rstmid_ignored got=1 want=0"); end
    ready_mode = 0; lat_lo = 1; lat_hi = 2;
    f = 1'b0; gi = '0; gp = '0;
    for (int c = 0; c < 20 && !f; c++) step(1'b1, f, gi, gp);
    total++; if (!f || gi !== 32'h0041_0113 || gp !== 32'h0) begin
      bad++; $display("FAIL rstmid_restart got=%h@%h want=00410113@00000000", gi, gp);
    end
    total++; if (proto_err != 0) begin bad++; $display("FAIL rstmid_one_outstanding got=%0d want=0", proto_err); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    exp_pc = 32'h0;
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_redirect_outstanding();
    test_random();
    test_reset_midrequest();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/instruction_aligner.md
INSTRUCTION_ALIGNER -- requirements
Module: instruction_aligner

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC of the first instruction after reset; bits[1:0] are ignored.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  output  1  fetch request to instruction memory.
REQ-005 req_ready  input  1  memory accepts request when req_valid && req_ready.
REQ-006 req_addr  output  32  word-aligned fetch address; bits[1:0] are always 0.
REQ-007 rsp_valid  input  1  memory read data valid; arrives 1 or more cycles after the accepting cycle.
REQ-008 rsp_data  input  32  fetched word; [15:0] is the lower-address halfword.
REQ-009 redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc.
REQ-010 redirect_pc  input  32  new PC; bit0 is treated as 0.
REQ-011 instr_valid  output  1  instr and instr_pc hold one complete instruction.
REQ-012 instr_ready  input  1  downstream parser stage consumes the instruction when instr_valid && instr_ready.
REQ-013 instr  output  32  32-bit instruction {hw1,hw0}, or 16-bit compressed instruction {16'h0,hw0}.
REQ-014 instr_pc  output  32  address of instr.

Function
REQ-015 The block SHALL keep a 4-entry halfword FIFO with count 0..4 and a head PC.
REQ-016 Head halfword hw0 with hw0[1:0]==2'b11 SHALL mean a 32-bit instruction; any other value SHALL mean a 16-bit instruction.
REQ-017 instr_valid SHALL be 1 when count>=2, or when count==1 and the instruction is 16-bit; otherwise 0.
REQ-018 instr_valid, instr and instr_pc SHALL be driven from registers only, with no combinational path from rsp_* or instr_ready.
REQ-019 On pop, the FIFO SHALL drop 1 halfword for a 16-bit instruction or 2 for a 32-bit one, and instr_pc SHALL advance by 2 or 4.
REQ-020 At most one request SHALL be outstanding at any time.
REQ-021 req_valid SHALL be asserted when there is no outstanding request, no redirect this cycle, and count minus halfwords popped this cycle is <=2.
REQ-022 req_valid SHALL hold, with req_addr stable, until accepted.
REQ-023 fetch_addr SHALL advance by 4 on each accepted request.
REQ-024 On rsp_valid, both halfwords SHALL be pushed in order [15:0] then [31:16], except for the first word after a redirect to a PC with bit1==1, where only [31:16] SHALL be pushed.
REQ-025 Push and pop in the same cycle SHALL both take effect; the FIFO SHALL never overflow, which REQ-021 guarantees.
REQ-026 Latency: a response at cycle N SHALL produce instr_valid at cycle N+1 when it completes an instruction.
REQ-027 On redirect_valid, the next cycle SHALL have count=0, instr_valid=0, instr_pc=redirect_pc, and fetch_addr=redirect_pc&~3.
REQ-028 Any pop in the redirect cycle SHALL be ignored.
REQ-029 Redirect SHALL take priority over push and pop.
REQ-030 A response to a request accepted before a redirect SHALL be discarded, tracked by a 1-bit epoch tag; the outstanding slot SHALL still be released on that response.
REQ-031 All address arithmetic SHALL be modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.

Reset
REQ-032 While rst is asserted, the block SHALL hold count=0, instr_valid=0, instr=0, instr_pc=RESET_PC, req_valid=0, req_addr=RESET_PC&~3, no outstanding request, and epoch=0.
REQ-033 Reset asserted mid-request SHALL abandon the request; a response arriving after reset with no outstanding request SHALL be ignored.

Structure
REQ-034 The halfword count width and the INSTR_SIZE_16/INSTR_SIZE_32 constants SHALL be placed in the shared rv32i package alongside rv32i_t.
REQ-035 The FIFO storage, count and push/pop logic SHALL be one sub-module, aligner_hw_fifo; fetch control, epoch and redirect logic SHALL remain in the top.

Verification
REQ-036 Reset, then respond word 32'h0041_0113 -> instr=32'h0041_0113, instr_pc=0, instr_valid one cycle after rsp_valid.
REQ-037 Respond word 32'h4501_4505 -> two instructions: 32'h0000_4505 @0, then 32'h0000_4501 @2.
REQ-038 Respond words 32'h0113_4505 then 32'h4505_0041 -> 32'h0000_4505 @0, 32'h0041_0113 @2 (spans words), 32'h0000_4505 @6.
REQ-039 Hold instr_ready=0 for 10 cycles -> count never exceeds 4, req_valid stays low once count>2, and instr/instr_pc stay stable.
REQ-040 Redirect to 32'h0000_0102 while a request is outstanding -> stale response dropped, next req_addr=32'h100, first instr_pc=32'h102 from rsp_data[31:16].
REQ-041 Assert rst while req_valid is high and a response is pending -> outputs reach their reset values immediately and the late rsp_valid is ignored.
